spi_ahb_loader: RTL and testbench
=================================

# spi_ahb_loader

SPI-slave program loader and AHB-Lite write initiator. Receives a host byte stream over SPI mode 0: a 32-bit start address, then 32-bit data words. Each word is issued as a single-beat AHB write into the router's SPI master port, at auto-incrementing addresses. Drives `spi_change` so the router hands the memories to the core once a load completes.

## Interface
Parameters:
- `SYNC_STAGES`, 2: synchronizer depth on `spi_sclk`, `spi_cs_n` and `spi_mosi`; legal values ≥2.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: reset reset, synchronous, active-high; clock clk.
- `spi_sclk` in 1: SPI clock, asynchronous; frequency ≤ clk/8.
- `spi_cs_n` in 1: SPI chip select, active low.
- `spi_mosi` in 1: SPI data in, MSB first.
- `spi_miso` out 1: echo of the previous complete byte, MSB first.
- `haddr` out 32: AHB address.
- `hwdata` out 32: AHB write data.
- `hwrite` out 1: constant 1.
- `hsize` out 3: constant 3'b010.
- `hburst` out 3: constant 3'b000 (SINGLE).
- `hmastlock` out 1: constant 0.
- `hprot` out 4: constant 4'b0011.
- `htrans` out 2: 2'b00 IDLE or 2'b10 NONSEQ.
- `hready` in 1: AHB ready.
- `hresp` in 1: AHB response; 1 = ERROR.
- `hrdata` in 32: unused.
- `spi_change` out 1: 0 = SPI owns memories; 1 = core owns them.
- `err` out 1: sticky AHB error flag.
- `overrun` out 1: sticky word-buffer overrun flag.

## Operation
- **Input conditioning:** `SYNC_STAGES` flops on each SPI input. Edges are detected on the synchronized signals:
  - `sclk` rise: sample `mosi`.
  - `sclk` fall: shift `miso`.
  - `cs_n` fall: frame start.
  - `cs_n` rise: frame end.
- **Frame start:**
  - Bit count and byte count cleared.
  - `err` and `overrun` cleared.
  - `spi_change` driven 0.
  - Word counter cleared.
  - `miso` shift register loaded with 0x00.
- **Byte assembly:** 3-bit bit counter, MSB first. Bytes 0–3 of the frame form the start address, big-endian; that value goes to the address register.
- **Data words:** each subsequent 4 bytes form a data word.
  - Without the configuration macro, byte order is big-endian (first byte → [31:24]).
  - A completed word loads a single-entry buffer and sets `pending`.
- **Overrun:** if a word completes while `pending` = 1, `overrun` is set and the new word is dropped.
- **AHB state machine:**
  - `IDLE`: `htrans` = 00. If `pending`, go to `ADDR`.
  - `ADDR`: `htrans` = 10, `haddr` = address register. Stay while `hready` = 0. On `hready` = 1, go to `DATA`.
  - `DATA`: `htrans` = 00, `hwdata` = buffer. Stay while `hready` = 0. On `hready` = 1:
    - clear `pending`;
    - add 4 to the address register (mod 2^32, wraps 0xFFFFFFFC → 0x00000000);
    - increment the word counter;
    - if `hresp` = 1, set `err`;
    - go to `IDLE`.
- **Frame end:**
  - A partial byte or partial word is discarded.
  - An in-flight or pending transfer still completes.
  - `spi_change` goes to 1 once `cs_n` is high, FSM is `IDLE`, `pending` = 0 and word counter ≥ 1.
  - A frame with fewer than 8 bytes leaves `spi_change` at 0.
- **Reset mid-operation:** all state returns to reset values. An in-flight transfer is abandoned (`htrans` = 00 the next cycle).

## Timing
- **Reset values:**
  - `htrans` = 00, `haddr` = 0, `hwdata` = 0;
  - `spi_change` = 0, `err` = 0, `overrun` = 0, `spi_miso` = 0;
  - FSM in `IDLE`, `pending` = 0.
- **Word to bus:** the cycle after the last `sclk` rise is detected, `pending` = 1. `ADDR` (NONSEQ) is driven the following cycle.
- **Minimum transfer length:** 2 cycles with `hready` held high (`ADDR` + `DATA`).
- **Input latency:** edge detection lags the pins by `SYNC_STAGES`+1 clk cycles.
- **`spi_change` assertion:** 1 cycle after the last condition is met.
- **`spi_change` deassertion:** the cycle after `cs_n` fall is detected.
- **Simultaneous events:**
  - Word completes in the same cycle `DATA` finishes: the new word is accepted, no overrun.
  - `cs_n` fall while `spi_change` = 1: `spi_change` clears; any remaining transfer continues.

## Configuration
- `SPI_LOADER_BYTE_SWAP_EN`
  - Defined: data words are assembled little-endian (first data byte → `hwdata[7:0]`, fourth → [31:24]) for direct RISC-V image loading.
  - Undefined: big-endian (first byte → [31:24]).
- The start-address bytes are always big-endian.

## Test plan
- **Single word:** frame 00 00 00 10, DE AD BE EF, `hready` = 1 → one NONSEQ at `haddr` 0x00000010, `hwdata` 0xDEADBEEF; `spi_change` = 1 after `cs_n` rise.
- **Three words:** frame from 0x00004000 → writes at 0x4000, 0x4004, 0x4008 in order; `err` = 0, `overrun` = 0.
- **Wait states and overrun:** `hready` low for 3 cycles in `ADDR` and 2 in `DATA` → `haddr`/`htrans` held stable, transfer completes. With `hready` held low for 600 cycles across two word completions → `overrun` = 1, second word dropped.
- **Error and short frames:** `hresp` = 1 in the `DATA` cycle → `err` = 1, cleared on the next `cs_n` fall. Frame of 6 bytes → no AHB transfer, `spi_change` stays 0.
- **Wrap and reset:** start address 0xFFFFFFFC with 2 words → second write at 0x00000000. Reset asserted during `ADDR` → next cycle `htrans` = 00, all flags 0.
- **Byte swap:** with `SPI_LOADER_BYTE_SWAP_EN` defined, data bytes 13 00 00 00 → `hwdata` 0x00000013.

Source files
------------

// File: rtl/spi_ahb_loader_if.sv
// AHB-Lite write bundle between the SPI program loader (master) and the router's SPI port (slave).
interface spi_ahb_loader_if;
    logic [31:0] haddr;
    logic [31:0] hwdata;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic        hmastlock;
    logic [3:0]  hprot;
    logic [1:0]  htrans;
    logic        hready;
    logic        hresp;
    logic [31:0] hrdata;

    modport master (
        output haddr, hwdata, hwrite, hsize, hburst, hmastlock, hprot, htrans,
        input  hready, hresp, hrdata
    );
    modport slave (
        input  haddr, hwdata, hwrite, hsize, hburst, hmastlock, hprot, htrans,
        output hready, hresp, hrdata
    );
endinterface

// File: rtl/spi_ahb_loader.sv
// SPI mode-0 slave that loads a start address plus data words and writes them over AHB-Lite.
// Optional SPI_LOADER_BYTE_SWAP_EN assembles data words little-endian (address stays big-endian).
module spi_ahb_loader #(
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             spi_sclk,
    input  logic             spi_cs_n,
    input  logic             spi_mosi,
    output logic             spi_miso,
    spi_ahb_loader_if.master ahb,
    output logic             spi_change,
    output logic             err,
    output logic             overrun
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic        sclk_prev_q, sclk_prev_d;
    logic        cs_prev_q, cs_prev_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [6:0]  byte_sr_q, byte_sr_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic        addr_done_q, addr_done_d;
    logic [31:0] word_sr_q, word_sr_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] buf_q, buf_d;
    logic        pending_q, pending_d;
    logic [1:0]  state_q, state_d;
    logic [15:0] word_cnt_q, word_cnt_d;
    logic [7:0]  miso_sr_q, miso_sr_d;
    logic [7:0]  last_byte_q, last_byte_d;
    logic        spi_change_q, spi_change_d;
    logic        err_q, err_d;
    logic        overrun_q, overrun_d;

    logic        sclk_s, cs_s, mosi_s, cs_active;
    logic        sclk_rise, sclk_fall, frame_start;
    logic        byte_done, word_done, data_done;
    logic [7:0]  new_byte;
    logic [31:0] addr_word, data_word;

    assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s        = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
    assign cs_active   = ~cs_s;
    assign sclk_rise   = cs_active & sclk_s & ~sclk_prev_q;
    assign sclk_fall   = cs_active & ~sclk_s & sclk_prev_q;
    assign frame_start = ~cs_s & cs_prev_q;
    assign new_byte    = {byte_sr_q, mosi_s};
    assign byte_done   = sclk_rise & (bit_cnt_q == 3'd7);
    assign word_done   = byte_done & (byte_idx_q == 2'd3);
    assign data_done   = (state_q == ST_DATA) & ahb.hready;
    assign addr_word   = {word_sr_q[23:0], new_byte};
`ifdef SPI_LOADER_BYTE_SWAP_EN
    assign data_word   = {new_byte, word_sr_q[31:8]};
`else
    assign data_word   = addr_word;
`endif

    always_comb begin
        sclk_sync_d  = {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
        cs_sync_d    = {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
        mosi_sync_d  = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
        sclk_prev_d  = sclk_s;
        cs_prev_d    = cs_s;
        bit_cnt_d    = bit_cnt_q;
        byte_sr_d    = byte_sr_q;
        byte_idx_d   = byte_idx_q;
        addr_done_d  = addr_done_q;
        word_sr_d    = word_sr_q;
        addr_d       = addr_q;
        buf_d        = buf_q;
        pending_d    = pending_q;
        state_d      = state_q;
        word_cnt_d   = word_cnt_q;
        miso_sr_d    = miso_sr_q;
        last_byte_d  = last_byte_q;
        spi_change_d = spi_change_q;
        err_d        = err_q;
        overrun_d    = overrun_q;

        case (state_q)
            ST_IDLE: if (pending_q) state_d = ST_ADDR;
            ST_ADDR: if (ahb.hready) state_d = ST_DATA;
            ST_DATA: if (ahb.hready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (data_done) begin
            pending_d = 1'b0;
            addr_d    = addr_q + 32'd4;
            if (word_cnt_q != 16'hFFFF) word_cnt_d = word_cnt_q + 16'd1;
            if (ahb.hresp) err_d = 1'b1;
        end

        if (state_q == ST_IDLE && !pending_q && cs_s && word_cnt_q != 16'd0)
            spi_change_d = 1'b1;

        if (sclk_rise) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            byte_sr_d = new_byte[6:0];
            if (byte_done) begin
                last_byte_d = new_byte;
                byte_idx_d  = byte_idx_q + 2'd1;
                word_sr_d   = addr_done_q ? data_word : addr_word;
            end
        end

        // A word finishing alongside DATA completion reuses the buffer being freed.
        if (word_done && !addr_done_q) begin
            addr_done_d = 1'b1;
            addr_d      = addr_word;
        end else if (word_done) begin
            if (pending_q && !data_done) begin
                overrun_d = 1'b1;
            end else begin
                buf_d     = data_word;
                pending_d = 1'b1;
            end
        end

        // Reload on the fall after a byte completes so its MSB is ready for the next rise.
        if (sclk_fall)
            miso_sr_d = (bit_cnt_q == 3'd0) ? last_byte_q : {miso_sr_q[6:0], 1'b0};

        if (frame_start) begin
            bit_cnt_d    = 3'd0;
            byte_idx_d   = 2'd0;
            addr_done_d  = 1'b0;
            err_d        = 1'b0;
            overrun_d    = 1'b0;
            spi_change_d = 1'b0;
            word_cnt_d   = 16'd0;
            miso_sr_d    = 8'h00;
            last_byte_d  = 8'h00;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_sync_q  <= '0;
            cs_sync_q    <= '1;
            mosi_sync_q  <= '0;
            sclk_prev_q  <= 1'b0;
            cs_prev_q    <= 1'b1;
            bit_cnt_q    <= 3'd0;
            byte_sr_q    <= 7'd0;
            byte_idx_q   <= 2'd0;
            addr_done_q  <= 1'b0;
            word_sr_q    <= 32'd0;
            addr_q       <= 32'd0;
            buf_q        <= 32'd0;
            pending_q    <= 1'b0;
            state_q      <= ST_IDLE;
            word_cnt_q   <= 16'd0;
            miso_sr_q    <= 8'h00;
            last_byte_q  <= 8'h00;
            spi_change_q <= 1'b0;
            err_q        <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            sclk_sync_q  <= sclk_sync_d;
            cs_sync_q    <= cs_sync_d;
            mosi_sync_q  <= mosi_sync_d;
            sclk_prev_q  <= sclk_prev_d;
            cs_prev_q    <= cs_prev_d;
            bit_cnt_q    <= bit_cnt_d;
            byte_sr_q    <= byte_sr_d;
            byte_idx_q   <= byte_idx_d;
            addr_done_q  <= addr_done_d;
            word_sr_q    <= word_sr_d;
            addr_q       <= addr_d;
            buf_q        <= buf_d;
            pending_q    <= pending_d;
            state_q      <= state_d;
            word_cnt_q   <= word_cnt_d;
            miso_sr_q    <= miso_sr_d;
            last_byte_q  <= last_byte_d;
            spi_change_q <= spi_change_d;
            err_q        <= err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign spi_miso      = miso_sr_q[7];
    assign spi_change    = spi_change_q;
    assign err           = err_q;
    assign overrun       = overrun_q;
    assign ahb.haddr     = addr_q;
    assign ahb.hwdata    = buf_q;
    assign ahb.htrans    = (state_q == ST_ADDR) ? 2'b10 : 2'b00;
    assign ahb.hwrite    = 1'b1;
    assign ahb.hsize     = 3'b010;
    assign ahb.hburst    = 3'b000;
    assign ahb.hmastlock = 1'b0;
    assign ahb.hprot     = 4'b0011;
endmodule

// File: tb/tb_spi_ahb_loader.sv
// Randomized self-checking bench for spi_ahb_loader: frames are turned into expected AHB writes
// by a byte-level model and compared with transfers captured from the bus.
module tb_spi_ahb_loader;
    logic clk = 1'b0;
    logic reset;
    logic spi_sclk, spi_cs_n, spi_mosi, spi_miso;
    logic spi_change, err, overrun;

    spi_ahb_loader_if bus ();

    spi_ahb_loader #(.SYNC_STAGES(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .spi_sclk   (spi_sclk),
        .spi_cs_n   (spi_cs_n),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso),
        .ahb        (bus.master),
        .spi_change (spi_change),
        .err        (err),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int wait_pct = 0;
    bit hold_low = 1'b0;
    bit in_data = 1'b0;
    bit hold_pending = 1'b0;
    logic [31:0] hold_addr;
    logic [7:0]  tx_bytes[$];
    logic [31:0] exp_addr[$], exp_data[$], got_addr[$], got_data[$];

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // hready changes just after each rising edge so the bus sees it at the next one.
    initial begin
        bus.hready = 1'b1;
        bus.hresp  = 1'b0;
        bus.hrdata = 32'd0;
        forever begin
            @(posedge clk);
            #2;
            bus.hready = hold_low ? 1'b0 : ($urandom_range(0, 99) >= wait_pct);
        end
    end

    // Bus monitor: captures completed writes and checks address-phase stability under wait states.
    initial forever begin
        @(negedge clk);
        if (reset) begin
            in_data      = 1'b0;
            hold_pending = 1'b0;
        end else begin
            if (hold_pending) begin
                checkOutput("haddr_hold", bus.haddr, hold_addr);
                checkOutput("htrans_hold", {30'd0, bus.htrans}, 32'd2);
                hold_pending = 1'b0;
            end
            if (in_data && bus.hready) begin
                got_data.push_back(bus.hwdata);
                in_data = 1'b0;
            end
            if (bus.htrans == 2'b10) begin
                if (bus.hready) begin
                    got_addr.push_back(bus.haddr);
                    in_data = 1'b1;
                end else begin
                    hold_pending = 1'b1;
                    hold_addr    = bus.haddr;
                end
            end
        end
    end

    task automatic spiBit(input logic b, input logic exp_miso);
        spi_mosi = b;
        repeat (8) @(posedge clk);
        #1 checkOutput("spi_miso", {31'd0, spi_miso}, {31'd0, exp_miso});
        spi_sclk = 1'b1;
        repeat (8) @(posedge clk);
        #1 spi_sclk = 1'b0;
    endtask

    task automatic applyStimulus();
        logic [7:0] cur, prev;
        spi_cs_n = 1'b0;
        repeat (16) @(posedge clk);
        #1;
        checkOutput("start_err_clr", {31'd0, err}, 32'd0);
        checkOutput("start_ovr_clr", {31'd0, overrun}, 32'd0);
        checkOutput("start_chg_clr", {31'd0, spi_change}, 32'd0);
        for (int i = 0; i < tx_bytes.size(); i++) begin
            cur  = tx_bytes[i];
            prev = (i == 0) ? 8'h00 : tx_bytes[i-1];
            for (int b = 7; b >= 0; b--) spiBit(cur[b], prev[b]);
        end
        repeat (8) @(posedge clk);
        #1 spi_cs_n = 1'b1;
        checkOutput("chg_before_end", {31'd0, spi_change}, 32'd0);
    endtask

    task automatic makeFrame(input logic [31:0] start, input int words);
        tx_bytes.delete();
        tx_bytes.push_back(start[31:24]);
        tx_bytes.push_back(start[23:16]);
        tx_bytes.push_back(start[15:8]);
        tx_bytes.push_back(start[7:0]);
        for (int i = 0; i < 4 * words; i++) tx_bytes.push_back(8'($urandom));
    endtask

    task automatic buildExpected(input int max_words);
        logic [31:0] base, w;
        int nwords, k;
        exp_addr.delete();
        exp_data.delete();
        if (tx_bytes.size() < 4) return;
        base   = {tx_bytes[0], tx_bytes[1], tx_bytes[2], tx_bytes[3]};
        nwords = (tx_bytes.size() - 4) / 4;
        if (nwords > max_words) nwords = max_words;
        for (int i = 0; i < nwords; i++) begin
            k = 4 + 4 * i;
`ifdef SPI_LOADER_BYTE_SWAP_EN
            w = {tx_bytes[k+3], tx_bytes[k+2], tx_bytes[k+1], tx_bytes[k]};
`else
            w = {tx_bytes[k], tx_bytes[k+1], tx_bytes[k+2], tx_bytes[k+3]};
`endif
            exp_addr.push_back(base + 32'(4 * i));
            exp_data.push_back(w);
        end
    endtask

    task automatic checkScoreboard();
        checkOutput("xfer_count", 32'(got_addr.size()), 32'(exp_addr.size()));
        checkOutput("data_count", 32'(got_data.size()), 32'(exp_data.size()));
        for (int i = 0; i < exp_addr.size() && i < got_addr.size() && i < got_data.size(); i++) begin
            checkOutput("xfer_addr", got_addr[i], exp_addr[i]);
            checkOutput("xfer_data", got_data[i], exp_data[i]);
        end
        got_addr.delete();
        got_data.delete();
    endtask

    task automatic waitChange();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (spi_change) break;
        end
        checkOutput("spi_change_set", {31'd0, spi_change}, 32'd1);
    endtask

    task automatic runFrame(input int max_words);
        buildExpected(max_words);
        applyStimulus();
        waitChange();
        checkScoreboard();
    endtask

    initial begin
        reset    = 1'b1;
        spi_sclk = 1'b0;
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("rst_htrans", {30'd0, bus.htrans}, 32'd0);
        checkOutput("rst_haddr", bus.haddr, 32'd0);
        checkOutput("rst_hwdata", bus.hwdata, 32'd0);
        checkOutput("rst_flags", {28'd0, spi_change, err, overrun, spi_miso}, 32'd0);
        checkOutput("const_ctrl", {20'd0, bus.hwrite, bus.hsize, bus.hburst, bus.hmastlock, bus.hprot},
                    {20'd0, 1'b1, 3'b010, 3'b000, 1'b0, 4'b0011});
        reset = 1'b0;
        repeat (4) @(posedge clk);

        $display("[TB] single word");
        tx_bytes = '{8'h00, 8'h00, 8'h00, 8'h10, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        runFrame(99);

        $display("[TB] three words from 0x4000");
        makeFrame(32'h0000_4000, 3);
        runFrame(99);
        checkOutput("err_clean", {31'd0, err}, 32'd0);
        checkOutput("ovr_clean", {31'd0, overrun}, 32'd0);

        $display("[TB] random frames with wait states");
        for (int n = 0; n < 6; n++) begin
            wait_pct = $urandom_range(0, 70);
            makeFrame($urandom, $urandom_range(1, 3));
            runFrame(99);
            checkOutput("rand_err", {31'd0, err}, 32'd0);
            checkOutput("rand_ovr", {31'd0, overrun}, 32'd0);
        end

        $display("[TB] address wrap");
        wait_pct = 30;
        makeFrame(32'hFFFF_FFFC, 2);
        runFrame(99);

        $display("[TB] overrun with hready held low");
        wait_pct = 0;
        hold_low = 1'b1;
        makeFrame($urandom, 2);
        buildExpected(1);
        applyStimulus();
        checkOutput("overrun_set", {31'd0, overrun}, 32'd1);
        hold_low = 1'b0;
        waitChange();
        checkScoreboard();

        $display("[TB] error response");
        bus.hresp = 1'b1;
        makeFrame($urandom, 1);
        runFrame(99);
        checkOutput("err_set", {31'd0, err}, 32'd1);
        bus.hresp = 1'b0;

        $display("[TB] short frame of 6 bytes");
        tx_bytes = '{8'h00, 8'h00, 8'h20, 8'h00, 8'h55, 8'hAA};
        buildExpected(99);
        applyStimulus();
        repeat (100) @(posedge clk);
        #1 checkOutput("short_no_chg", {31'd0, spi_change}, 32'd0);
        checkScoreboard();

        $display("[TB] reset during address phase");
        hold_low = 1'b1;
        makeFrame($urandom, 1);
        applyStimulus();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.htrans == 2'b10) break;
        end
        checkOutput("reached_addr", {30'd0, bus.htrans}, 32'd2);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rst_mid_htrans", {30'd0, bus.htrans}, 32'd0);
        checkOutput("rst_mid_flags", {29'd0, spi_change, err, overrun}, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        hold_low = 1'b0;
        repeat (50) @(posedge clk);
        got_data.delete();
        checkOutput("post_rst_xfers", 32'(got_addr.size()), 32'd0);
        got_addr.delete();

        $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
